// File: rtl/hdlc_tx_sched_if.sv
// Requester byte streams, HDLC register write port and Tx status between scheduler and its environment.
interface hdlc_tx_sched_if;
  logic       Req0_Valid;
  logic       Req1_Valid;
  logic [7:0] Req0_Data;
  logic [7:0] Req1_Data;
  logic       Req0_Last;
  logic       Req1_Last;
  logic       Req0_Ready;
  logic       Req1_Ready;
  logic [1:0] Grant;
  logic [2:0] Address;
  logic [7:0] Data_In;
  logic       WriteEnable;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;
  logic       Done_Pulse;
  logic       Err_Pulse;
  logic       Done_Id;
  logic       Busy;

  modport master (
    input  Req0_Valid, Req1_Valid, Req0_Data, Req1_Data, Req0_Last, Req1_Last,
    input  Tx_Done, Tx_AbortedTrans,
    output Req0_Ready, Req1_Ready, Grant, Address, Data_In, WriteEnable,
    output Done_Pulse, Err_Pulse, Done_Id, Busy
  );

  modport slave (
    output Req0_Valid, Req1_Valid, Req0_Data, Req1_Data, Req0_Last, Req1_Last,
    output Tx_Done, Tx_AbortedTrans,
    input  Req0_Ready, Req1_Ready, Grant, Address, Data_In, WriteEnable,
    input  Done_Pulse, Err_Pulse, Done_Id, Busy
  );
endinterface

// File: rtl/hdlc_tx_sched.sv
// Two-requester round-robin frame scheduler for an HDLC Tx: each accepted byte becomes a register write one cycle later,
// Ready only toward the owner; watchdog in WAIT_DONE exists only with HDLC_SCHED_TIMEOUT_EN defined.
module hdlc_tx_sched #(
  parameter int MAX_BYTES      = 126,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic             Clk,
  input logic             Rst,
  hdlc_tx_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, DRAIN, ABORT} state_t;

  localparam logic [6:0] LAST_CNT = 7'(MAX_BYTES - 1);

  if (MAX_BYTES < 1 || MAX_BYTES > 127) begin : g_max_bytes_out_of_range
  end
  if (TIMEOUT_CYCLES < 3 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
  end

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       prio_q, prio_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] hold_q, hold_d;
  logic       ovl_q, ovl_d;
  logic       we_q, we_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       id_q, id_d;
  logic       owner, rx_open, sel_vld, sel_last, acc, fin;
  logic [7:0] sel_dat;

`ifdef HDLC_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
`endif

  assign owner    = grant_q[1];
  assign rx_open  = (state_q == LOAD) || (state_q == DRAIN);
  assign sel_vld  = owner ? bus.Req1_Valid : bus.Req0_Valid;
  assign sel_dat  = owner ? bus.Req1_Data  : bus.Req0_Data;
  assign sel_last = owner ? bus.Req1_Last  : bus.Req0_Last;
  assign acc      = rx_open && sel_vld;

  assign bus.Req0_Ready  = rx_open && grant_q[0];
  assign bus.Req1_Ready  = rx_open && grant_q[1];
  assign bus.Grant       = grant_q;
  assign bus.Address     = addr_q;
  assign bus.Data_In     = data_q;
  assign bus.WriteEnable = we_q;
  assign bus.Done_Pulse  = done_q;
  assign bus.Err_Pulse   = err_q;
  assign bus.Done_Id     = id_q;
  assign bus.Busy        = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ovl_d   = ovl_q;
    we_d    = 1'b0;
    addr_d  = 3'h0;
    data_d  = 8'h00;
    done_d  = 1'b0;
    err_d   = 1'b0;
    id_d    = 1'b0;
    fin     = 1'b0;
`ifdef HDLC_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Req0_Valid || bus.Req1_Valid) begin
          // prio_q names the requester favoured on a tie
          grant_d = (bus.Req1_Valid && (!bus.Req0_Valid || prio_q)) ? 2'b10 : 2'b01;
          cnt_d   = 7'd0;
          ovl_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (acc) begin
          we_d   = 1'b1;
          addr_d = 3'h1;
          data_d = sel_dat;
          cnt_d  = cnt_q + 7'd1;
          if (sel_last) begin
            state_d = START;
          end else if (cnt_q == LAST_CNT) begin
            ovl_d   = 1'b1;
            state_d = ABORT;
          end
        end
      end
      START: begin
        we_d    = 1'b1;
        addr_d  = 3'h0;
        data_d  = 8'h02;
        hold_d  = 2'd0;
`ifdef HDLC_SCHED_TIMEOUT_EN
        wd_d    = 16'd0;
`endif
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
`ifdef HDLC_SCHED_TIMEOUT_EN
        wd_d = wd_q + 16'd1;
`endif
        // status is blind for the first two cycles after Tx_Enable
        if (hold_q != 2'd2) begin
          hold_d = hold_q + 2'd1;
        end else if (bus.Tx_AbortedTrans) begin
          err_d = 1'b1;
          id_d  = owner;
          fin   = 1'b1;
        end else if (bus.Tx_Done) begin
          done_d = 1'b1;
          id_d   = owner;
          fin    = 1'b1;
        end
`ifdef HDLC_SCHED_TIMEOUT_EN
        if (!fin && (wd_q == WD_LAST)) state_d = ABORT;
`endif
      end
      ABORT: begin
        we_d   = 1'b1;
        addr_d = 3'h0;
        data_d = 8'h04;
        if (ovl_q) begin
          state_d = DRAIN;
        end else begin
          err_d = 1'b1;
          id_d  = owner;
          fin   = 1'b1;
        end
      end
      DRAIN: begin
        if (acc && sel_last) begin
          err_d = 1'b1;
          id_d  = owner;
          fin   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      grant_d = 2'b00;
      prio_d  = ~owner;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
      cnt_q   <= 7'd0;
      hold_q  <= 2'd0;
      ovl_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 3'h0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
`ifdef HDLC_SCHED_TIMEOUT_EN
      wd_q    <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ovl_q   <= ovl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      id_q    <= id_d;
`ifdef HDLC_SCHED_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end
endmodule

// File: tb/tb_hdlc_tx_sched.sv
// Directed bench for hdlc_tx_sched: writes, pulses and grants are logged on the falling edge and compared against hand-derived values.
module tb_hdlc_tx_sched;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  hdlc_tx_sched_if bus();

  hdlc_tx_sched #(.MAX_BYTES(126), .TIMEOUT_CYCLES(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int idle_bad = 0;
  int bad_ack = 0;
  int t_start = -1;
  int t_flush = -1;
  int bad = 0;
  bit stop_drv = 1'b0;

  logic [10:0] wr_q[$];
  int          wr_t[$];
  logic [2:0]  ev_q[$];
  int          ev_t[$];
  logic [1:0]  g_q[$];
  int          g_t[$];
  logic [1:0]  g_prev = 2'b00;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // falling-edge monitor: every write, pulse and grant change gets a cycle stamp
  always @(negedge Clk) begin
    if (bus.WriteEnable) begin
      wr_q.push_back({bus.Address, bus.Data_In});
      wr_t.push_back(cyc);
    end else if (bus.Address != 3'h0 || bus.Data_In != 8'h00) begin
      idle_bad <= idle_bad + 1;
    end
    if (bus.Done_Pulse || bus.Err_Pulse) begin
      ev_q.push_back({bus.Done_Pulse, bus.Err_Pulse, bus.Done_Id});
      ev_t.push_back(cyc);
    end
    if ((bus.Req0_Valid && bus.Req0_Ready && !bus.Grant[0]) ||
        (bus.Req1_Valid && bus.Req1_Ready && !bus.Grant[1]))
      bad_ack <= bad_ack + 1;
    if (bus.Grant != g_prev) begin
      g_q.push_back(bus.Grant);
      g_t.push_back(cyc);
    end
    g_prev <= bus.Grant;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 11'h7FF;
  endfunction
  function automatic int wr_t_at(input int i);
    if (i < wr_t.size()) return wr_t[i];
    return -1000;
  endfunction
  function automatic logic [2:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 3'b111;
  endfunction
  function automatic int ev_t_at(input int i);
    if (i < ev_t.size()) return ev_t[i];
    return -1000;
  endfunction
  function automatic logic [1:0] g_at(input int i);
    if (i < g_q.size()) return g_q[i];
    return 2'b11;
  endfunction
  function automatic int g_t_at(input int i);
    if (i < g_t.size()) return g_t[i];
    return -1000;
  endfunction

  task automatic clear_logs();
    wr_q.delete(); wr_t.delete();
    ev_q.delete(); ev_t.delete();
    g_q.delete();  g_t.delete();
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.Grant, bus.Req0_Ready, bus.Req1_Ready, bus.WriteEnable, bus.Address,
            bus.Data_In, bus.Done_Pulse, bus.Err_Pulse, bus.Done_Id, bus.Busy};
  endfunction

  task automatic drive(input int id, input int limit);
    int waited = 0;
    while (!stop_drv && ((id == 0) ? q0.size() : q1.size()) != 0) begin
      @(negedge Clk);
      if (stop_drv) break;
      if (id == 0) begin
        bus.Req0_Valid = 1'b1;
        bus.Req0_Data  = q0[0];
        bus.Req0_Last  = (q0.size() == 1);
        if (bus.Req0_Ready) void'(q0.pop_front());
      end else begin
        bus.Req1_Valid = 1'b1;
        bus.Req1_Data  = q1[0];
        bus.Req1_Last  = (q1.size() == 1);
        if (bus.Req1_Ready) void'(q1.pop_front());
      end
      waited++;
      if (waited > limit) begin
        check_eq($sformatf("drv%0d_budget", id), waited, limit);
        break;
      end
    end
    @(negedge Clk);
    if (id == 0) begin
      bus.Req0_Valid = 1'b0; bus.Req0_Last = 1'b0; bus.Req0_Data = 8'h00;
    end else begin
      bus.Req1_Valid = 1'b0; bus.Req1_Last = 1'b0; bus.Req1_Data = 8'h00;
    end
  endtask

  task automatic wait_wr(input string tag, input logic [10:0] val, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clk);
      if (bus.WriteEnable && {bus.Address, bus.Data_In} == val) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq(tag, 0, 1);
  endtask

  task automatic respond(input int delay, input logic done, input logic abrt);
    int w0;
    wait_wr("resp_no_tx_enable", 11'h002, 600, w0);
    t_start = w0;
    if (w0 < 0) return;
    repeat (delay) @(negedge Clk);
    bus.Tx_Done = done;
    bus.Tx_AbortedTrans = abrt;
    @(negedge Clk);
    bus.Tx_Done = 1'b0;
    bus.Tx_AbortedTrans = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench hung");
  end

  initial begin
    bus.Req0_Valid = 1'b1; bus.Req0_Data = 8'h00; bus.Req0_Last = 1'b0;
    bus.Req1_Valid = 1'b1; bus.Req1_Data = 8'h00; bus.Req1_Last = 1'b0;
    bus.Tx_Done = 1'b0; bus.Tx_AbortedTrans = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("reset_outputs", all_outs(), 32'h0);
    bus.Req0_Valid = 1'b0;
    bus.Req1_Valid = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); clear_logs();

    // single frame from Req0; status pulses during the blind window must be ignored
    q0 = '{8'hA5, 8'h3C, 8'h7E};
    fork
      drive(0, 50);
      begin
        wait_wr("t1_no_tx_enable", 11'h002, 50, t_start);
        if (t_start >= 0) begin
          bus.Tx_Done = 1'b1;
          @(negedge Clk);
          @(negedge Clk);
          bus.Tx_Done = 1'b0;
          check_eq("t1_blind_window", {bus.Busy, bus.Done_Pulse, bus.Err_Pulse}, 3'b100);
          @(negedge Clk);
          bus.Tx_Done = 1'b1;
          @(negedge Clk);
          bus.Tx_Done = 1'b0;
        end
      end
    join
    repeat (2) @(negedge Clk);
    check_eq("t1_wr_count", wr_q.size(), 4);
    check_eq("t1_wr0", wr_at(0), 11'h1A5);
    check_eq("t1_wr1", wr_at(1), 11'h13C);
    check_eq("t1_wr2", wr_at(2), 11'h17E);
    check_eq("t1_wr3", wr_at(3), 11'h002);
    check_eq("t1_grant", g_at(0), 2'b01);
    check_eq("t1_wr_latency", wr_t_at(0) - g_t_at(0), 1);
    check_eq("t1_ev_count", ev_q.size(), 1);
    check_eq("t1_ev", ev_at(0), 3'b100);
    check_eq("t1_ev_time", ev_t_at(0) - t_start, 4);

    // both requesters valid after reset: 0 first, 1 next, one idle cycle apart
    @(negedge Clk); Rst = 1'b0;
    repeat (2) @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); clear_logs();
    q0 = '{8'h11, 8'h22};
    q1 = '{8'h33, 8'h44};
    fork
      drive(0, 60);
      drive(1, 60);
      begin respond(2, 1'b1, 1'b0); respond(2, 1'b1, 1'b0); end
    join
    repeat (2) @(negedge Clk);
    check_eq("t2_ev_count", ev_q.size(), 2);
    check_eq("t2_ev0", ev_at(0), 3'b100);
    check_eq("t2_ev1", ev_at(1), 3'b101);
    check_eq("t2_grant_first", g_at(0), 2'b01);
    check_eq("t2_grant_gap", g_at(1), 2'b00);
    check_eq("t2_grant_second", g_at(2), 2'b10);
    check_eq("t2_idle_cycles", g_t_at(2) - g_t_at(1), 1);
    check_eq("t2_wr3", wr_at(3), 11'h133);

    // overlong frame from Req1: 126 writes, flush, 4 drained bytes, error
    @(posedge Clk); clear_logs();
    for (int i = 0; i < 130; i++) q1.push_back(8'(i));
    drive(1, 400);
    repeat (3) @(negedge Clk);
    check_eq("t3_wr_count", wr_q.size(), 127);
    bad = 0;
    for (int i = 0; i < 126; i++) if (wr_at(i) != {3'h1, 8'(i)}) bad++;
    check_eq("t3_payload_bad", bad, 0);
    check_eq("t3_flush", wr_at(126), 11'h004);
    check_eq("t3_flush_time", wr_t_at(126) - wr_t_at(125), 1);
    check_eq("t3_ev_count", ev_q.size(), 1);
    check_eq("t3_ev", ev_at(0), 3'b011);
    check_eq("t3_ev_time", ev_t_at(0) - wr_t_at(126), 4);

    // abort and done together: error wins
    @(posedge Clk); clear_logs();
    q0 = '{8'h5A};
    fork
      drive(0, 30);
      respond(3, 1'b1, 1'b1);
    join
    repeat (2) @(negedge Clk);
    check_eq("t4_wr_count", wr_q.size(), 2);
    check_eq("t4_ev_count", ev_q.size(), 1);
    check_eq("t4_ev", ev_at(0), 3'b010);
    check_eq("t4_ev_time", ev_t_at(0) - t_start, 4);

    // reset mid-frame, then a clean MAX_BYTES frame ending in Last
    @(posedge Clk); clear_logs();
    q1 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    stop_drv = 1'b0;
    fork
      drive(1, 40);
      begin
        for (int i = 0; i < 40 && wr_q.size() < 2; i++) @(posedge Clk);
        check_eq("t5_two_writes", wr_q.size(), 2);
        #2;
        Rst = 1'b0;
        stop_drv = 1'b1;
        #1;
        check_eq("t5_outs_in_reset", all_outs(), 32'h0);
      end
    join
    repeat (3) @(negedge Clk);
    check_eq("t5_no_pulse", ev_q.size(), 0);
    check_eq("t5_no_more_writes", wr_q.size(), 2);
    check_eq("t5_outs_held", all_outs(), 32'h0);
    q1.delete();
    stop_drv = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); clear_logs();
    for (int i = 0; i < 126; i++) q1.push_back(8'h80 ^ 8'(i));
    fork
      drive(1, 300);
      respond(2, 1'b1, 1'b0);
    join
    repeat (2) @(negedge Clk);
    check_eq("t5_wr_count", wr_q.size(), 127);
    check_eq("t5_first_byte", wr_at(0), 11'h180);
    check_eq("t5_tx_enable", wr_at(126), 11'h002);
    check_eq("t5_ev", ev_at(0), 3'b101);

    @(posedge Clk); clear_logs();
    q0 = '{8'hE1};
`ifdef HDLC_SCHED_TIMEOUT_EN
    // Tx_Done never arrives: WAIT_DONE lasts 16 cycles, then flush and error
    fork
      drive(0, 30);
      begin
        wait_wr("t6_no_tx_enable", 11'h002, 30, t_start);
        wait_wr("t6_no_flush", 11'h004, 40, t_flush);
      end
    join
    repeat (2) @(negedge Clk);
    check_eq("t6_flush_time", t_flush - t_start, 17);
    check_eq("t6_ev", ev_at(0), 3'b010);
    check_eq("t6_ev_time", ev_t_at(0), t_flush);
`else
    // without the watchdog the block waits for Tx_Done however long it takes
    fork
      drive(0, 30);
      wait_wr("t6_no_tx_enable", 11'h002, 30, t_start);
    join
    repeat (40) @(negedge Clk);
    check_eq("t6_still_busy", bus.Busy, 1'b1);
    check_eq("t6_no_pulse", ev_q.size(), 0);
    bus.Tx_Done = 1'b1;
    @(negedge Clk);
    bus.Tx_Done = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("t6_ev", ev_at(0), 3'b100);
`endif

    check_eq("wr_idle_nonzero", idle_bad, 0);
    check_eq("non_owner_ack", bad_ack, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
